// File: rtl/wid_byte_packer_pkg.sv
// Shared constants and helpers for the byte-to-word width converters.
package wid_pkg;

    localparam int unsigned BYTE_W = 8;
    // Widest keep vector the helpers support (WIDTH up to 1024 bits).
    localparam int unsigned MAX_NB = 128;

    // Number of byte lanes in a word of the given bit width.
    function automatic int unsigned byte_lanes(input int unsigned width);
        return width / BYTE_W;
    endfunction

    // One-hot lane mask; callers cast the result down to their own NB.
    function automatic logic [MAX_NB-1:0] keep_mask(input int unsigned idx);
        logic [MAX_NB-1:0] m;
        m = '0;
        if (idx < MAX_NB) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wid_byte_packer_reg_slice.sv
// Single-entry valid/ready register slice with full throughput.
module wid_reg_slice #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready_c,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    assign s_ready_c = !r_valid || m_ready;
    assign m_valid   = r_valid;
    assign m_data    = r_data;

    // Load on upstream push; otherwise drain on downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (s_valid && s_ready_c) begin
            r_valid <= 1'b1;
            r_data  <= s_data;
        end else if (m_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wid_byte_packer.sv
// Packs an 8-bit valid/ready byte stream little-endian into WIDTH-bit words with keep/last.
module wid_byte_packer
    import wid_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BYTE_W-1:0]           in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [byte_lanes(WIDTH)-1:0] out_keep,
    output logic                        out_last
);

    localparam int unsigned NB = byte_lanes(WIDTH);
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned SW = WIDTH + NB + 1;

    if ((WIDTH < BYTE_W) || ((WIDTH % BYTE_W) != 0)) begin : g_width_err
        $error("wid_byte_packer: WIDTH must be a non-zero multiple of 8");
    end
    if (NB > MAX_NB) begin : g_nb_err
        $error("wid_byte_packer: WIDTH exceeds keep_mask range");
    end

    logic [WIDTH-1:0] r_acc;
    logic [NB-1:0]    r_keep;
    logic [CW-1:0]    r_idx;

    logic             w_ready;
    logic             w_accept;
    logic             w_complete;
    logic [CW+2:0]    w_shift;
    logic [WIDTH-1:0] w_merged;
    logic [NB-1:0]    w_keep_next;
    logic [SW-1:0]    w_slice_in;
    logic [SW-1:0]    w_slice_out;

    assign in_ready   = w_ready;
    assign w_accept   = in_valid && w_ready;
    assign w_complete = w_accept && ((r_idx == CW'(NB - 1)) || in_last);

    // Lanes at and above r_idx are always zero, so OR-merging is exact.
    assign w_shift     = {r_idx, 3'b000};
    assign w_merged    = r_acc | (WIDTH'(in_data) << w_shift);
    assign w_keep_next = r_keep | NB'(keep_mask(32'(r_idx)));
    assign w_slice_in  = {in_last, w_keep_next, w_merged};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_keep <= '0;
            r_idx  <= '0;
        end else if (w_complete) begin
            r_acc  <= '0;
            r_keep <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_acc  <= w_merged;
            r_keep <= w_keep_next;
            r_idx  <= r_idx + CW'(1);
        end
    end

    wid_reg_slice #(
        .DW(SW)
    ) u_out_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (w_complete),
        .s_ready_c(w_ready),
        .s_data   (w_slice_in),
        .m_valid  (out_valid),
        .m_ready  (out_ready),
        .m_data   (w_slice_out)
    );

    assign out_data = w_slice_out[WIDTH-1:0];
    assign out_keep = w_slice_out[WIDTH +: NB];
    assign out_last = w_slice_out[SW-1];

endmodule

// File: tb/tb_wid_byte_packer.sv
// Directed bench for wid_byte_packer at WIDTH=32 and WIDTH=8.
module tb_wid_byte_packer;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [7:0]  in_data;
    logic [31:0] out_data;
    logic [3:0]  out_keep;

    logic        v8, ir8, l8, ov8, r8, ol8;
    logic [7:0]  d8, od8;
    logic [0:0]  ok8;

    int n_checks;
    int n_err;

    wid_byte_packer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last)
    );

    wid_byte_packer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(ir8), .in_data(d8), .in_last(l8),
        .out_valid(ov8), .out_ready(r8), .out_data(od8),
        .out_keep(ok8), .out_last(ol8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        rdy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic        exp_last;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic rdy, input logic ir, input logic ov,
                                input logic [31:0] data, input logic [3:0] keep,
                                input logic last);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.rdy = rdy; t.exp_ir = ir; t.exp_ov = ov;
        t.exp_data = data; t.exp_keep = keep; t.exp_last = last;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] data, input logic [3:0] keep,
                              input logic last);
        check({tag, " out_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " out_data"},  64'(out_data),  64'(data));
        check({tag, " out_keep"},  64'(out_keep),  64'(keep));
        check({tag, " out_last"},  64'(out_last),  64'(last));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        v8 = 1'b0; d8 = 8'h00; l8 = 1'b0; r8 = 1'b0;

        // Table: tests 1-4 plus last-on-first-byte, no-bubble reload and ignored idle inputs.
        tbl[0]  = mk(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[1]  = mk(1, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[2]  = mk(1, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[3]  = mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0);
        tbl[4]  = mk(1, 8'hAA, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[5]  = mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1);
        tbl[6]  = mk(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[7]  = mk(1, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[8]  = mk(1, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[9]  = mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0);
        tbl[10] = mk(1, 8'h55, 0, 0, 0, 1, 32'h44332211, 4'hF, 0);
        tbl[11] = mk(1, 8'h55, 0, 0, 0, 1, 32'h44332211, 4'hF, 0);
        tbl[12] = mk(1, 8'h55, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[13] = mk(1, 8'h66, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[14] = mk(1, 8'h77, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[15] = mk(1, 8'h88, 0, 1, 1, 1, 32'h88776655, 4'hF, 0);
        tbl[16] = mk(1, 8'h01, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[17] = mk(1, 8'h02, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[18] = mk(1, 8'h03, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[19] = mk(1, 8'h04, 0, 1, 1, 1, 32'h04030201, 4'hF, 0);
        tbl[20] = mk(1, 8'h05, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[21] = mk(1, 8'h06, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[22] = mk(1, 8'h07, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[23] = mk(1, 8'h08, 0, 1, 1, 1, 32'h08070605, 4'hF, 0);
        tbl[24] = mk(1, 8'h99, 1, 1, 1, 1, 32'h00000099, 4'h1, 1);
        tbl[25] = mk(0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[26] = mk(0, 8'hFF, 1, 1, 1, 0, 32'h0,        4'h0, 0);
        tbl[27] = mk(1, 8'h12, 1, 1, 1, 1, 32'h00000012, 4'h1, 1);
        tbl[28] = mk(0, 8'h00, 0, 0, 0, 1, 32'h00000012, 4'h1, 1);
        tbl[29] = mk(0, 8'h00, 0, 1, 1, 0, 32'h0,        4'h0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'(1'b0));
        check("reset out_data",  64'(out_data),  64'(32'h0));
        check("reset out_keep",  64'(out_keep),  64'(4'h0));
        check("reset out_last",  64'(out_last),  64'(1'b0));
        check("reset w8 out_valid", 64'(ov8), 64'(1'b0));
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready",    64'(in_ready), 64'(1'b1));
        check("post-reset w8 in_ready", 64'(ir8),      64'(1'b1));

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdy);
            #1;
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].exp_ir));
            tick();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tbl[i].exp_data));
                check($sformatf("vec%0d out_keep", i), 64'(out_keep), 64'(tbl[i].exp_keep));
                check($sformatf("vec%0d out_last", i), 64'(out_last), 64'(tbl[i].exp_last));
            end
        end

        // Reset mid-word: stale output data and partial lanes must vanish.
        drive(1'b1, 8'hC7, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hC8, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'(1'b0));
        check("midreset out_data",  64'(out_data),  64'(32'h0));
        check("midreset out_keep",  64'(out_keep),  64'(4'h0));
        check("midreset out_last",  64'(out_last),  64'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'hC1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b1);
        tick();
        check("after-reset partial out_valid", 64'(out_valid), 64'(1'b0));
        drive(1'b1, 8'hC4, 1'b0, 1'b1);
        tick();
        check_word("after-reset word", 32'hC4C3C2C1, 4'hF, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("after-reset drain out_valid", 64'(out_valid), 64'(1'b0));

        // WIDTH=8: every byte completes with one-cycle latency.
        v8 = 1'b1; d8 = 8'h5A; l8 = 1'b0; r8 = 1'b1;
        #1;
        check("w8 first in_ready", 64'(ir8), 64'(1'b1));
        tick();
        check("w8 first out_valid", 64'(ov8),  64'(1'b1));
        check("w8 first out_data",  64'(od8),  64'(8'h5A));
        check("w8 first out_keep",  64'(ok8),  64'(1'b1));
        check("w8 first out_last",  64'(ol8),  64'(1'b0));
        d8 = 8'hA5; l8 = 1'b1;
        #1;
        check("w8 second in_ready", 64'(ir8), 64'(1'b1));
        tick();
        check("w8 second out_valid", 64'(ov8), 64'(1'b1));
        check("w8 second out_data",  64'(od8), 64'(8'hA5));
        check("w8 second out_keep",  64'(ok8), 64'(1'b1));
        check("w8 second out_last",  64'(ol8), 64'(1'b1));
        v8 = 1'b0; l8 = 1'b0; r8 = 1'b0;
        tick();
        check("w8 hold out_valid", 64'(ov8), 64'(1'b1));
        check("w8 hold out_data",  64'(od8), 64'(8'hA5));
        check("w8 stalled in_ready", 64'(ir8), 64'(1'b0));
        r8 = 1'b1;
        tick();
        check("w8 drain out_valid", 64'(ov8), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
